pipe_logic_chain: RTL

- Parametrised, elastic, valid/ready pipeline of DEPTH registered logic stages, each W bits wide.
- Every stage applies a per-beat selectable bitwise operation: pass, invert, rotate-left, or AND-with-inverted-rotate. These are the INV/AND/NOR-style cones between flops, generalised.
- Used as a scalable sequential benchmark and datapath filler: timing depth and width grow with parameters, and behaviour stays exactly checkable.
- Also keeps a wrapping count of delivered beats.

---
 rtl/pipe_logic_chain_pkg.sv | 33 +++
 rtl/pipe_logic_chain_if.sv | 29 ++
 rtl/pipe_logic_chain_stage.sv | 41 ++++
 rtl/pipe_logic_chain.sv | 58 +++++
 4 files changed

// File: rtl/pipe_logic_chain_pkg.sv
// Shared mode encodings and the per-stage logic operation for pipe_logic_chain.
// No state; the op function is pure combinational and width-agnostic up to MAX_W.
// Backpressure: not applicable (package only).
package pipe_logic_chain_pkg;

  // Widest data path the op function supports; instances must keep W <= MAX_W.
  localparam int MAX_W = 64;

  localparam logic [1:0] MODE_PASS = 2'd0;
  localparam logic [1:0] MODE_INV  = 2'd1;
  localparam logic [1:0] MODE_ROTL = 2'd2;
  localparam logic [1:0] MODE_ANDN = 2'd3;

  // op(m,d) on the low w bits of d; rotl is {d[w-2:0], d[w-1]}.
  // Upper bits above w are always returned as zero.
  function automatic logic [MAX_W-1:0] op_apply(input logic [1:0] m,
                                                input logic [MAX_W-1:0] d,
                                                input int unsigned w);
    logic [MAX_W-1:0] mask;
    logic [MAX_W-1:0] dm;
    logic [MAX_W-1:0] rot;
    mask = (w >= MAX_W) ? {MAX_W{1'b1}} : ((MAX_W'(1) << w) - MAX_W'(1));
    dm   = d & mask;
    rot  = ((dm << 1) | (dm >> (w - 1))) & mask;
    case (m)
      MODE_PASS: op_apply = dm;
      MODE_INV:  op_apply = ~dm & mask;
      MODE_ROTL: op_apply = rot;
      default:   op_apply = dm & ~rot;
    endcase
  endfunction

endpackage

// File: rtl/pipe_logic_chain_if.sv
// Upstream/downstream handshake bundle for pipe_logic_chain.
// No latency of its own; pure wiring.
// Backpressure: in_ready/out_ready valid-ready pairs plus the delivered-beat count.
interface pipe_logic_chain_if #(
  parameter int W     = 8,
  parameter int CNT_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     in_data;
  logic [1:0]       in_mode;
  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     out_data;
  logic [1:0]       out_mode;
  logic [CNT_W-1:0] beat_cnt;

  // Traffic source / sink side (testbench or surrounding logic).
  modport master (
    output in_valid, in_data, in_mode, out_ready,
    input  in_ready, out_valid, out_data, out_mode, beat_cnt
  );

  // Pipeline side.
  modport slave (
    input  in_valid, in_data, in_mode, out_ready,
    output in_ready, out_valid, out_data, out_mode, beat_cnt
  );
endinterface

// File: rtl/pipe_logic_chain_stage.sv
// One elastic pipeline register applying op(mode,data) as it loads a beat.
// Latency: 1 cycle per stage.
// Backpressure: ready = !valid | next_ready, combinational from downstream; holds while stalled.
module pipe_logic_stage
  import pipe_logic_chain_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         prev_valid,
  input  logic [W-1:0] prev_data,
  input  logic [1:0]   prev_mode,
  input  logic         next_ready,
  output logic         ready,
  output logic         valid,
  output logic [W-1:0] data,
  output logic [1:0]   mode
);

  logic [W-1:0] op_res;

  assign ready  = !valid | next_ready;
  assign op_res = W'(op_apply(prev_mode, MAX_W'(prev_data), W));

  // Load the upstream beat when free or draining; bubbles only move the valid bit.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid <= 1'b0;
      data  <= '0;
      mode  <= '0;
    end else if (ready) begin
      valid <= prev_valid;
      if (prev_valid) begin
        data <= op_res;
        mode <= prev_mode;
      end
    end
  end

endmodule

// File: rtl/pipe_logic_chain.sv
// DEPTH-stage elastic chain of bitwise logic stages with a wrapping delivered-beat counter.
// Latency: DEPTH cycles accept-to-deliver, one beat per cycle throughput.
// Backpressure: in_ready ripples combinationally from out_ready; full pipe accepts while draining.
module pipe_logic_chain
  import pipe_logic_chain_pkg::*;
#(
  parameter int W     = 8,
  parameter int DEPTH = 3,
  parameter int CNT_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  pipe_logic_chain_if.slave bus
);

  // Index k is the input side of stage k; index DEPTH is the chain output.
  logic         src_valid [DEPTH+1];
  logic [W-1:0] src_data  [DEPTH+1];
  logic [1:0]   src_mode  [DEPTH+1];
  logic         rdy       [DEPTH+1];
  logic [CNT_W-1:0] cnt_q;

  assign src_valid[0] = bus.in_valid;
  assign src_data[0]  = bus.in_data;
  assign src_mode[0]  = bus.in_mode;
  assign rdy[DEPTH]   = bus.out_ready;

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    pipe_logic_stage #(.W(W)) u_stage (
      .clk        (clk),
      .rst_n      (rst_n),
      .prev_valid (src_valid[k]),
      .prev_data  (src_data[k]),
      .prev_mode  (src_mode[k]),
      .next_ready (rdy[k+1]),
      .ready      (rdy[k]),
      .valid      (src_valid[k+1]),
      .data       (src_data[k+1]),
      .mode       (src_mode[k+1])
    );
  end

  assign bus.in_ready  = rdy[0];
  assign bus.out_valid = src_valid[DEPTH];
  assign bus.out_data  = src_data[DEPTH];
  assign bus.out_mode  = src_mode[DEPTH];
  assign bus.beat_cnt  = cnt_q;

  // Count deliveries only; wraps naturally at 2^CNT_W.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (src_valid[DEPTH] && bus.out_ready) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

endmodule
